pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//  Parametrised hazard/forwarding controller for the MIPS pipeline, successor to the ID-stage combinational bypass logic.
//  Keeps its own scoreboard of in-flight destination registers, FWD_STAGES deep (stage 0 = EXE).
//  Generates rs/rt forwarding selects, load-use stalls and multi-cycle MDU (mult/multu) busy stalls.
//  Sits beside the ID stage; decode supplies per-instruction usage flags.
// PARAMETERS
//  REG_AW      5  register address width
//  FWD_STAGES  3  tracked stages after ID (EXE, MEM, WB), >=1
//  MDU_LAT     4  cycles HI/LO stay busy after a mult/multu issues; 0 = never busy
//  SEL_W       $clog2(FWD_STAGES+1)  forwarding select width (derived)
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  ext_stall     in   1       global freeze (e.g. dmem not ready); scoreboard holds
//  id_valid      in   1       ID holds a real instruction
//  id_rsc        in   REG_AW  rs address
//  id_rtc        in   REG_AW  rt address
//  id_rs_use     in   1       instruction reads rs
//  id_rt_use     in   1       instruction reads rt
//  id_rdc        in   REG_AW  destination address
//  id_rd_we      in   1       instruction writes the regfile
//  id_is_load    in   1       instruction is lw
//  id_is_mdu     in   1       mult/multu/mthi/mtlo (writes HI/LO)
//  id_reads_hilo in   1       mfhi/mflo
//  rs_fwd_sel    out  SEL_W   0 = regfile, k = forward from tracked stage k-1
//  rt_fwd_sel    out  SEL_W   as rs_fwd_sel
//  id_stall      out  1       hold PC and IF/ID
//  ex_bubble     out  1       inject NOP into ID/EXE this cycle
//  mdu_busy      out  1       MDU counter nonzero
// BEHAVIOUR
//  - Entry per stage: {vld, rdc, is_load}. Reset: all vld=0, mdu counter=0; all outputs 0.
//  - Advance on every clk when !ext_stall: st[k] <= st[k-1]; st[0] <= issue ? {1,id_rdc,id_is_load} : 0.
//    issue = id_valid & !id_stall & id_rd_we & (id_rdc!=0). When ext_stall=1 all entries hold.
//  - Forward select (combinational): smallest k with st[k].vld & st[k].rdc==src & use -> sel=k+1; else 0.
//    Source $0 always gives sel 0. The youngest producer wins.
//  - load_use = st[0].vld & st[0].is_load & (rs match & id_rs_use | rt match & id_rt_use).
//  - mdu_hazard = mdu_busy & (id_is_mdu | id_reads_hilo).
//  - id_stall = id_valid & (load_use | mdu_hazard); ex_bubble = id_stall & !ext_stall.
//  - A stall inserts a bubble at st[0]. The load moves to st[1] and is then forwarded (sel=2), so the stall lasts 1 cycle.
//  - MDU counter: loaded with MDU_LAT on issue of an id_is_mdu op (id_valid & !id_stall & !ext_stall).
//    Otherwise it decrements each cycle while nonzero, and keeps counting during ext_stall.
//    Load and nonzero cannot coincide because of the stall.
//  - Latency: select and stall outputs are combinational from inputs and state; the scoreboard updates 1 cycle after issue.
//  - Reset asserted mid-operation clears the scoreboard and counter immediately; no stall persists.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs perf_lu_cnt[31:0] and perf_mdu_cnt[31:0].
//    They count cycles with load_use or mdu_hazard stall respectively. Saturating, reset to 0.
//  Not defined: ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  hazard_pkg: typedef sb_entry_t {vld, rdc, is_load}; localparam FWD_RF=0; MDU_CNT_W=$clog2(MDU_LAT+1).
//  Sub-module mdu_busy_timer (load/decrement counter, busy flag). Scoreboard and select are inline.
// TESTING
//  - addu $3 then addu $4,$3,$3 back-to-back -> rs_fwd_sel=rt_fwd_sel=1, no stall.
//  - lw $5 then addu $6,$5,$0 -> id_stall=1, ex_bubble=1 for 1 cycle; next cycle rs_fwd_sel=2, rt_fwd_sel=0.
//  - addu $7 followed by addu $7 then read $7 -> sel=1 (youngest), not 2; write to $0 then read $0 -> sel=0.
//  - mult then mflo at once (MDU_LAT=4) -> id_stall for 4 cycles, mdu_busy falls, mflo issues on cycle 5.
//  - lw $5 and ext_stall=1 for 3 cycles with a dependent instruction in ID -> st held, stall held; then 1 bubble.
//  - Reset pulse while mdu_busy=1 and load-use pending -> all outputs 0 at once; perf counters (if enabled) = 0.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types, constants and width helpers for pipe_hazard_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    // Forward-select code meaning "take the operand from the register file".
    localparam int unsigned FWD_RF     = 0;
    localparam int unsigned REG_AW_DEF = 5;

    // Scoreboard entry at the default register-address width.
    typedef struct packed {
        logic                  vld;
        logic [REG_AW_DEF-1:0] rdc;
        logic                  is_load;
    } sb_entry_t;

    // Width of the MDU countdown; a zero latency still needs a 1-bit counter.
    function automatic int unsigned mdu_cnt_w(input int unsigned lat);
        return (lat > 0) ? $clog2(lat + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_unit_if.sv
// ============================================================================
// Module   : pipe_hazard_unit_if
// Brief    : ID-stage decode flags in, forwarding selects and stalls out.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned SEL_W  = 2
);
    logic              ext_stall;
    logic              id_valid;
    logic [REG_AW-1:0] id_rsc;
    logic [REG_AW-1:0] id_rtc;
    logic              id_rs_use;
    logic              id_rt_use;
    logic [REG_AW-1:0] id_rdc;
    logic              id_rd_we;
    logic              id_is_load;
    logic              id_is_mdu;
    logic              id_reads_hilo;
    logic [SEL_W-1:0]  rs_fwd_sel;
    logic [SEL_W-1:0]  rt_fwd_sel;
    logic              id_stall;
    logic              ex_bubble;
    logic              mdu_busy;

    modport master (
        output ext_stall, id_valid, id_rsc, id_rtc, id_rs_use, id_rt_use,
               id_rdc, id_rd_we, id_is_load, id_is_mdu, id_reads_hilo,
        input  rs_fwd_sel, rt_fwd_sel, id_stall, ex_bubble, mdu_busy
    );

    modport slave (
        input  ext_stall, id_valid, id_rsc, id_rtc, id_rs_use, id_rt_use,
               id_rdc, id_rd_we, id_is_load, id_is_mdu, id_reads_hilo,
        output rs_fwd_sel, rt_fwd_sel, id_stall, ex_bubble, mdu_busy
    );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_unit_mdu_busy_timer.sv
// ============================================================================
// Module   : mdu_busy_timer
// Brief    : HI/LO busy countdown, reloaded on each MDU issue.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_busy_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_load,
    output logic      o_busy
);
    localparam int unsigned            c_cnt_w = mdu_cnt_w(MDU_LAT);
    localparam logic [c_cnt_w-1:0]     c_lat   = c_cnt_w'(MDU_LAT);

    logic [c_cnt_w-1:0] r_cnt;

    // Keeps counting through a global freeze: the multiplier itself never stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_lat;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
// ============================================================================
// Module   : pipe_hazard_unit
// Brief    : Scoreboard-based forwarding / load-use / MDU hazard controller.
//            Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned FWD_STAGES = 3,
    parameter int unsigned MDU_LAT    = 4,
    parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pipe_hazard_unit_if.slave hif
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_lu_cnt,
    output logic [31:0]       perf_mdu_cnt
`endif
);
    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rdc;
        logic              is_load;
    } sb_slot_t;

    sb_slot_t         r_st [FWD_STAGES];
    logic [SEL_W-1:0] w_rs_sel;
    logic [SEL_W-1:0] w_rt_sel;
    logic             w_load_use;
    logic             w_mdu_hazard;
    logic             w_stall;
    logic             w_issue;
    logic             w_mdu_load;
    logic             w_mdu_busy;

    // Oldest-to-youngest scan so the youngest matching producer overwrites.
    always_comb begin
        w_rs_sel = SEL_W'(FWD_RF);
        w_rt_sel = SEL_W'(FWD_RF);
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (hif.id_rs_use && (hif.id_rsc != '0) && r_st[k].vld && (r_st[k].rdc == hif.id_rsc))
                w_rs_sel = SEL_W'(k + 1);
            if (hif.id_rt_use && (hif.id_rtc != '0) && r_st[k].vld && (r_st[k].rdc == hif.id_rtc))
                w_rt_sel = SEL_W'(k + 1);
        end
    end

    assign w_load_use   = r_st[0].vld && r_st[0].is_load &&
                          ((hif.id_rs_use && (r_st[0].rdc == hif.id_rsc)) ||
                           (hif.id_rt_use && (r_st[0].rdc == hif.id_rtc)));
    assign w_mdu_hazard = w_mdu_busy && (hif.id_is_mdu || hif.id_reads_hilo);
    assign w_stall      = hif.id_valid && (w_load_use || w_mdu_hazard);
    assign w_issue      = hif.id_valid && !w_stall && hif.id_rd_we && (hif.id_rdc != '0);
    assign w_mdu_load   = hif.id_valid && !w_stall && !hif.ext_stall && hif.id_is_mdu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st[0] <= '0;
        end else if (!hif.ext_stall) begin
            r_st[0] <= w_issue ? '{vld: 1'b1, rdc: hif.id_rdc, is_load: hif.id_is_load} : '0;
        end
    end

    for (genvar k = 1; k < FWD_STAGES; k++) begin : g_shift
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_st[k] <= '0;
            end else if (!hif.ext_stall) begin
                r_st[k] <= r_st[k-1];
            end
        end
    end

    mdu_busy_timer #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_mdu_load),
        .o_busy (w_mdu_busy)
    );

    assign hif.rs_fwd_sel = w_rs_sel;
    assign hif.rt_fwd_sel = w_rt_sel;
    assign hif.id_stall   = w_stall;
    assign hif.ex_bubble  = w_stall && !hif.ext_stall;
    assign hif.mdu_busy   = w_mdu_busy;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_mdu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_lu  <= '0;
            r_perf_mdu <= '0;
        end else begin
            if (hif.id_valid && w_load_use && (r_perf_lu != '1))
                r_perf_lu <= r_perf_lu + 32'd1;
            if (hif.id_valid && w_mdu_hazard && (r_perf_mdu != '1))
                r_perf_mdu <= r_perf_mdu + 32'd1;
        end
    end

    assign perf_lu_cnt  = r_perf_lu;
    assign perf_mdu_cnt = r_perf_mdu;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
// ============================================================================
// Module   : tb_pipe_hazard_unit
// Brief    : Directed vector table, hand sequences and random run vs model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_unit;
    localparam int FWD = 3;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.REG_AW(5), .SEL_W(2)) hif ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu, perf_mdu;
`endif

    pipe_hazard_unit #(
        .REG_AW     (5),
        .FWD_STAGES (FWD),
        .MDU_LAT    (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lu_cnt  (perf_lu),
        .perf_mdu_cnt (perf_mdu)
`endif
    );

    int errors = 0;
    int checks = 0;

    // rst, ext, v, rs, rsu, rt, rtu, rd, we, ld, mdu, hilo, e_rs, e_rt, e_stall, e_bub, e_busy
    typedef struct {
        int rst; int ext; int v; int rs; int rsu; int rt; int rtu; int rd;
        int we; int ld; int mdu; int hilo;
        int e_rs; int e_rt; int e_stall; int e_bub; int e_busy;
    } vec_t;

    // Reference model: queue indexed by age (0 = just issued into EXE).
    typedef struct { bit vld; int rd; bit ld; } ent_t;
    ent_t sbq[$];
    int   m_mdu;
    int   m_plu;
    int   m_pmdu;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        sbq.delete();
        for (int i = 0; i < FWD; i++) sbq.push_back('{0, 0, 0});
        m_mdu  = 0;
        m_plu  = 0;
        m_pmdu = 0;
    endfunction

    function automatic int m_sel(input int src, input bit use_src);
        if (!use_src || src == 0) return 0;
        foreach (sbq[k]) if (sbq[k].vld && sbq[k].rd == src) return k + 1;
        return 0;
    endfunction

    function automatic bit m_lu();
        return sbq[0].vld && sbq[0].ld &&
               ((hif.id_rs_use && sbq[0].rd == int'(hif.id_rsc)) ||
                (hif.id_rt_use && sbq[0].rd == int'(hif.id_rtc)));
    endfunction

    function automatic bit m_haz();
        return (m_mdu > 0) && (hif.id_is_mdu || hif.id_reads_hilo);
    endfunction

    function automatic bit m_stall();
        return hif.id_valid && (m_lu() || m_haz());
    endfunction

    // Applies what the next rising edge does to the model.
    function automatic void m_advance();
        ent_t e;
        bit   st;
        st = m_stall();
        if (hif.id_valid && m_lu())  m_plu++;
        if (hif.id_valid && m_haz()) m_pmdu++;
        if (hif.id_valid && !st && !hif.ext_stall && hif.id_is_mdu) m_mdu = LAT;
        else if (m_mdu > 0) m_mdu--;
        if (!hif.ext_stall) begin
            e = '{0, 0, 0};
            if (hif.id_valid && !st && hif.id_rd_we && hif.id_rdc != 0)
                e = '{1, int'(hif.id_rdc), hif.id_is_load};
            sbq.push_front(e);
            void'(sbq.pop_back());
        end
    endfunction

    task automatic drive(input vec_t t);
        @(negedge clk);
        hif.ext_stall     = (t.ext  != 0);
        hif.id_valid      = (t.v    != 0);
        hif.id_rsc        = 5'(t.rs);
        hif.id_rs_use     = (t.rsu  != 0);
        hif.id_rtc        = 5'(t.rt);
        hif.id_rt_use     = (t.rtu  != 0);
        hif.id_rdc        = 5'(t.rd);
        hif.id_rd_we      = (t.we   != 0);
        hif.id_is_load    = (t.ld   != 0);
        hif.id_is_mdu     = (t.mdu  != 0);
        hif.id_reads_hilo = (t.hilo != 0);
        #1;
    endtask

    task automatic do_reset();
        vec_t z;
        z = '{0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0};
        drive(z);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic chk_outs(input string tag, input int ers, input int ert,
                            input int est, input int ebub, input int ebusy);
        chk({tag, " rs_fwd_sel"}, int'(hif.rs_fwd_sel), ers);
        chk({tag, " rt_fwd_sel"}, int'(hif.rt_fwd_sel), ert);
        chk({tag, " id_stall"},   int'(hif.id_stall),   est);
        chk({tag, " ex_bubble"},  int'(hif.ex_bubble),  ebub);
        chk({tag, " mdu_busy"},   int'(hif.mdu_busy),   ebusy);
    endtask

    vec_t tbl [24];

    initial begin
        vec_t r;
        // Segment A: forwarding, load-use, youngest-wins, $0, mult/mflo.
        tbl[0]  = '{1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0};
        tbl[1]  = '{0,0,1,1,1,2,1,3,1,0,0,0, 0,0,0,0,0};
        tbl[2]  = '{0,0,1,3,1,3,1,4,1,0,0,0, 1,1,0,0,0};
        tbl[3]  = '{0,0,1,0,1,5,0,5,1,1,0,0, 0,0,0,0,0};
        tbl[4]  = '{0,0,1,5,1,0,1,6,1,0,0,0, 1,0,1,1,0};
        tbl[5]  = '{0,0,1,5,1,0,1,6,1,0,0,0, 2,0,0,0,0};
        tbl[6]  = '{0,0,1,0,1,0,1,7,1,0,0,0, 0,0,0,0,0};
        tbl[7]  = '{0,0,1,0,1,0,1,7,1,0,0,0, 0,0,0,0,0};
        tbl[8]  = '{0,0,1,7,1,0,1,8,1,0,0,0, 1,0,0,0,0};
        tbl[9]  = '{0,0,1,8,1,1,1,0,1,0,0,0, 1,0,0,0,0};
        tbl[10] = '{0,0,1,0,1,8,1,0,0,0,0,0, 0,2,0,0,0};
        tbl[11] = '{0,0,1,1,1,2,1,0,0,0,1,0, 0,0,0,0,0};
        tbl[12] = '{0,0,1,0,0,0,0,9,1,0,0,1, 0,0,1,1,1};
        tbl[13] = '{0,0,1,0,0,0,0,9,1,0,0,1, 0,0,1,1,1};
        tbl[14] = '{0,0,1,0,0,0,0,9,1,0,0,1, 0,0,1,1,1};
        tbl[15] = '{0,0,1,0,0,0,0,9,1,0,0,1, 0,0,1,1,1};
        tbl[16] = '{0,0,1,0,0,0,0,9,1,0,0,1, 0,0,0,0,0};
        tbl[17] = '{0,0,1,9,1,0,0,10,1,0,0,0, 1,0,0,0,0};
        // Segment B: load-use held through a 3-cycle freeze, then one bubble.
        tbl[18] = '{1,0,1,0,1,0,0,5,1,1,0,0, 0,0,0,0,0};
        tbl[19] = '{0,1,1,5,1,5,1,6,1,0,0,0, 1,1,1,0,0};
        tbl[20] = '{0,1,1,5,1,5,1,6,1,0,0,0, 1,1,1,0,0};
        tbl[21] = '{0,1,1,5,1,5,1,6,1,0,0,0, 1,1,1,0,0};
        tbl[22] = '{0,0,1,5,1,5,1,6,1,0,0,0, 1,1,1,1,0};
        tbl[23] = '{0,0,1,5,1,5,1,6,1,0,0,0, 2,2,0,0,0};

        m_reset();
        for (int i = 0; i < 24; i++) begin
            if (tbl[i].rst != 0) do_reset();
            drive(tbl[i]);
            chk_outs($sformatf("vec%0d", i), tbl[i].e_rs, tbl[i].e_rt,
                     tbl[i].e_stall, tbl[i].e_bub, tbl[i].e_busy);
            m_advance();
        end

        // Reset pulse while mdu_busy and a load-use stall are both active.
        do_reset();
        r = '{0,0,1,1,1,2,1,0,0,0,1,0, 0,0,0,0,0};
        drive(r); chk_outs("rst_seq mult", 0, 0, 0, 0, 0); m_advance();
        r = '{0,0,1,0,1,0,0,5,1,1,0,0, 0,0,0,0,0};
        drive(r); chk_outs("rst_seq lw", 0, 0, 0, 0, 1); m_advance();
        r = '{0,0,1,5,1,0,0,6,1,0,0,0, 0,0,0,0,0};
        drive(r); chk_outs("rst_seq dep", 1, 0, 1, 1, 1); m_advance();
        rst_n = 1'b0;
        #1;
        chk_outs("rst_seq async", 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_seq perf_lu", int'(perf_lu), 0);
        chk("rst_seq perf_mdu", int'(perf_mdu), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();

        // Random run against the model.
        for (int n = 0; n < 600; n++) begin
            r.rst  = 0;
            r.ext  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            r.v    = ($urandom_range(0, 7) != 0) ? 1 : 0;
            r.rs   = $urandom_range(0, 7);
            r.rsu  = $urandom_range(0, 1);
            r.rt   = $urandom_range(0, 7);
            r.rtu  = $urandom_range(0, 1);
            r.rd   = $urandom_range(0, 7);
            r.we   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            r.ld   = ($urandom_range(0, 2) == 0) ? 1 : 0;
            r.mdu  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            r.hilo = ($urandom_range(0, 7) == 0) ? 1 : 0;
            drive(r);
            chk_outs($sformatf("rnd%0d", n), m_sel(r.rs, r.rsu != 0), m_sel(r.rt, r.rtu != 0),
                     int'(m_stall()), int'(m_stall() && r.ext == 0), int'(m_mdu > 0));
            m_advance();
        end
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        chk("rnd perf_lu", int'(perf_lu), m_plu);
        chk("rnd perf_mdu", int'(perf_mdu), m_pmdu);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
